// File: rtl/seg7_scan_decoder_pkg.sv
// Shared 7-segment glyph definitions and segment-to-value decoding.
// SEG7_SCAN_HEX_EN adds the A..F glyphs to the legal decode set.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } scan_state_e;

  // Active-low segment patterns: bit 0 = a ... bit 6 = g.
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

  // Returns {legal, value}.
  function automatic logic [4:0] seg_to_val(input seg_t seg);
    logic [4:0] r;
    r = 5'b0;
    case (seg)
      SEG_0: r = {1'b1, 4'h0};
      SEG_1: r = {1'b1, 4'h1};
      SEG_2: r = {1'b1, 4'h2};
      SEG_3: r = {1'b1, 4'h3};
      SEG_4: r = {1'b1, 4'h4};
      SEG_5: r = {1'b1, 4'h5};
      SEG_6: r = {1'b1, 4'h6};
      SEG_7: r = {1'b1, 4'h7};
      SEG_8: r = {1'b1, 4'h8};
      SEG_9: r = {1'b1, 4'h9};
`ifdef SEG7_SCAN_HEX_EN
      SEG_A: r = {1'b1, 4'hA};
      SEG_B: r = {1'b1, 4'hB};
      SEG_C: r = {1'b1, 4'hC};
      SEG_D: r = {1'b1, 4'hD};
      SEG_E: r = {1'b1, 4'hE};
      SEG_F: r = {1'b1, 4'hF};
`endif
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_sync_stable.sv
// Two-flop synchronizer plus stability detector for the sampled display bus.
// o_stable_now strobes on the cycle the synchronized value has been held STABLE_CYCLES cycles.
module seg7_sync_stable #(
  parameter int STABLE_CYCLES = 4,
  parameter int W             = 15
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_bus,
  output logic [W-1:0] o_bus,
  output logic         o_changed,
  output logic         o_stable_now
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW:0]   HELD_TGT = (CW + 1)'(STABLE_CYCLES);

  logic [W-1:0]  r_s1;
  logic [W-1:0]  r_s2;
  logic [W-1:0]  r_prev;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW:0]   w_held;
  logic          w_changed;

  assign w_changed = (r_s2 != r_prev);
  assign w_cnt_nxt = w_changed ? '0 :
                     (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
  // The change cycle itself is the first cycle the new value is seen.
  assign w_held    = (CW + 1)'(w_cnt_nxt) + (CW + 1)'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_bus;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_bus        = r_s2;
  assign o_changed    = w_changed;
  assign o_stable_now = (w_held == HELD_TGT);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive decoder for a multiplexed active-low 8-digit 7-segment bus into a digit register file.
// Define SEG7_SCAN_HEX_EN to also accept the A..F glyphs.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_DIGITS-1:0]     i_an,
  input  logic [6:0]                i_seg,
  output logic [4*NUM_DIGITS-1:0]   o_digits,
  output logic [NUM_DIGITS-1:0]     o_digit_valid,
  output logic                      o_upd,
  output logic [2:0]                o_upd_idx,
  output logic                      o_err_pat,
  output logic                      o_err_an
);

  scan_state_e           r_state;
  logic [NUM_DIGITS+6:0] w_bus;
  logic                  w_changed;
  logic                  w_stable_now;
  logic [NUM_DIGITS-1:0] w_an;
  logic [NUM_DIGITS-1:0] w_an_low;
  seg_t                  w_seg;
  logic                  w_onehot;
  logic [2:0]            w_idx;
  logic [4:0]            w_dec;
  logic                  w_eval;

  seg7_sync_stable #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .W            (NUM_DIGITS + 7)
  ) u_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_bus       ({i_an, i_seg}),
    .o_bus       (w_bus),
    .o_changed   (w_changed),
    .o_stable_now(w_stable_now)
  );

  assign w_an  = w_bus[NUM_DIGITS+6:7];
  assign w_seg = w_bus[6:0];
  assign w_dec = seg_to_val(w_seg);

  always_comb begin
    w_an_low = ~w_an;
    w_onehot = (w_an_low != '0) && ((w_an_low & (w_an_low - 1'b1)) == '0);
    w_idx    = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an_low[i]) w_idx = 3'(i);
    end
  end

  // With STABLE_CYCLES=1 the strobe coincides with the change, so HOLD must evaluate too.
  assign w_eval = w_stable_now && ((r_state == ST_SETTLE) || w_changed);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_SETTLE;
      o_digits      <= '0;
      o_digit_valid <= '0;
      o_upd         <= 1'b0;
      o_upd_idx     <= 3'd0;
      o_err_pat     <= 1'b0;
      o_err_an      <= 1'b0;
    end else begin
      o_upd     <= 1'b0;
      o_err_pat <= 1'b0;
      o_err_an  <= 1'b0;

      case (r_state)
        ST_SETTLE: if (w_stable_now) r_state <= ST_HOLD;
        ST_HOLD:   if (w_changed && !w_stable_now) r_state <= ST_SETTLE;
        default:   r_state <= ST_SETTLE;
      endcase

      if (w_eval && (w_an_low != '0)) begin
        if (!w_onehot) begin
          o_err_an <= 1'b1;
        end else if (w_dec[4]) begin
          o_digits[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
          o_digit_valid[w_idx]          <= 1'b1;
          o_upd                         <= 1'b1;
          o_upd_idx                     <= w_idx;
        end else begin
          o_err_pat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: expected pulses are queued with stimulus and
// popped by a monitor whenever the DUT emits upd / err_pat / err_an.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an  = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        err_pat;
  logic        err_an;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] K_UPD = 2'd1;
  localparam logic [1:0] K_PAT = 2'd2;
  localparam logic [1:0] K_AN  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] idx;
    logic [3:0] val;
  } ev_t;

  ev_t exp_q[$];

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  seg7_scan_decoder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_an         (an),
    .i_seg        (seg),
    .o_digits     (digits),
    .o_digit_valid(digit_valid),
    .o_upd        (upd),
    .o_upd_idx    (upd_idx),
    .o_err_pat    (err_pat),
    .o_err_an     (err_an)
  );

  always @(negedge clk) begin
    logic [1:0] k;
    ev_t        e;
    if (rst === 1'b0 && (upd === 1'b1 || err_pat === 1'b1 || err_an === 1'b1)) begin
      case ({upd, err_pat, err_an})
        3'b100:  k = K_UPD;
        3'b010:  k = K_PAT;
        3'b001:  k = K_AN;
        default: k = 2'd0;
      endcase
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse t=%0t got kind=%0d idx=%0d (none expected)", $time, k, upd_idx);
      end else begin
        e = exp_q.pop_front();
        if (k !== e.kind ||
            (e.kind == K_UPD && (upd_idx !== e.idx || digits[4*e.idx +: 4] !== e.val))) begin
          bad++;
          $display("FAIL pulse t=%0t got kind=%0d idx=%0d val=%h, want kind=%0d idx=%0d val=%h",
                   $time, k, upd_idx, digits[4*upd_idx +: 4], e.kind, e.idx, e.val);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [6:0] s);
    @(negedge clk);
    an  = a;
    seg = s;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] k, input logic [2:0] idx, input logic [3:0] val);
    exp_q.push_back('{kind: k, idx: idx, val: val});
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if (digits !== 32'h0 || digit_valid !== 8'h0 || upd !== 1'b0 ||
        upd_idx !== 3'd0 || err_pat !== 1'b0 || err_an !== 1'b0) begin
      bad++;
      $display("FAIL %s got digits=%h valid=%h upd=%b idx=%0d ep=%b ea=%b, want all 0",
               tag, digits, digit_valid, upd, upd_idx, err_pat, err_an);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    an  = 8'hFF;
    seg = 7'h7F;
    wait_cyc(3);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    wait_cyc(12);
    total++;
    if (digit_valid !== 8'h00) begin
      bad++;
      $display("FAIL idle_blank got valid=%h want 00", digit_valid);
    end
  endtask

  task automatic test_latency();
    drive(8'hFE, 7'h30);
    push(K_UPD, 3'd0, 4'h3);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (upd !== (c == 6)) begin
        bad++;
        $display("FAIL latency clk=%0d got upd=%b want %b", c, upd, (c == 6));
      end
    end
    wait_cyc(4);
    total++;
    if (digits[3:0] !== 4'h3 || digit_valid !== 8'h01) begin
      bad++;
      $display("FAIL first_capture got d0=%h valid=%h want d0=3 valid=01", digits[3:0], digit_valid);
    end
  endtask

  task automatic test_scan();
    drive(8'hFE, 7'h79);
    push(K_UPD, 3'd0, 4'h1);
    wait_cyc(20);
    drive(8'h7F, 7'h10);
    push(K_UPD, 3'd7, 4'h9);
    wait_cyc(20);
    total++;
    if (digits[3:0] !== 4'h1 || digits[31:28] !== 4'h9 || digit_valid !== 8'h81) begin
      bad++;
      $display("FAIL scan got d0=%h d7=%h valid=%h want d0=1 d7=9 valid=81",
               digits[3:0], digits[31:28], digit_valid);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 15; i++) begin
      drive(8'hFB, (i % 2 == 0) ? 7'h79 : 7'h24);
      wait_cyc(1);
    end
    drive(8'hFB, 7'h12);
    push(K_UPD, 3'd2, 4'h5);
    wait_cyc(20);
    total++;
    if (digits[11:8] !== 4'h5 || digit_valid !== 8'h85) begin
      bad++;
      $display("FAIL glitch got d2=%h valid=%h want d2=5 valid=85", digits[11:8], digit_valid);
    end
  endtask

  task automatic test_all_glyphs();
    for (int v = 0; v < 10; v++) begin
      drive(8'hF7, glyph[v]);
      push(K_UPD, 3'd3, 4'(v));
      wait_cyc(12);
      total++;
      if (digits[15:12] !== 4'(v)) begin
        bad++;
        $display("FAIL glyph_%0d got d3=%h want %h", v, digits[15:12], 4'(v));
      end
    end
    drive(8'hFF, 7'h7F);
    wait_cyc(12);
    drive(8'hF7, glyph[9]);
    push(K_UPD, 3'd3, 4'h9);
    wait_cyc(12);
    total++;
    if (digit_valid !== 8'h8D) begin
      bad++;
      $display("FAIL rewrite_same got valid=%h want 8D", digit_valid);
    end
  endtask

  task automatic test_errors();
    drive(8'hFC, 7'h00);
    push(K_AN, 3'd0, 4'h0);
    wait_cyc(20);
    drive(8'hFD, 7'h7E);
    push(K_PAT, 3'd0, 4'h0);
    wait_cyc(20);
    total++;
    if (digits[7:4] !== 4'h0 || digit_valid !== 8'h8D || digits[3:0] !== 4'h1) begin
      bad++;
      $display("FAIL errors got d1=%h d0=%h valid=%h want d1=0 d0=1 valid=8D",
               digits[7:4], digits[3:0], digit_valid);
    end
  endtask

  task automatic test_hex();
    drive(8'hFE, 7'h08);
`ifdef SEG7_SCAN_HEX_EN
    push(K_UPD, 3'd0, 4'hA);
    wait_cyc(20);
    total++;
    if (digits[3:0] !== 4'hA) begin
      bad++;
      $display("FAIL hex_glyph got d0=%h want A", digits[3:0]);
    end
`else
    push(K_PAT, 3'd0, 4'h0);
    wait_cyc(20);
    total++;
    if (digits[3:0] !== 4'h1) begin
      bad++;
      $display("FAIL hex_rejected got d0=%h want 1", digits[3:0]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    drive(8'hFE, 7'h30);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset_mid_settle");
    @(negedge clk);
    rst = 1'b0;
    push(K_UPD, 3'd0, 4'h3);
    wait_cyc(15);
    total++;
    if (digits !== 32'h0000_0003 || digit_valid !== 8'h01) begin
      bad++;
      $display("FAIL post_reset_capture got digits=%h valid=%h want 00000003 01", digits, digit_valid);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_scan();
    test_glitch();
    test_all_glyphs();
    test_errors();
    test_hex();
    test_reset_mid();
    wait_cyc(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reverse direction of the team's BCD-to-7-segment driver.
- Passively monitors a multiplexed, active-low 8-digit 7-segment bus (an[7:0], seg[6:0]), for example the board display lines or another unit's driver outputs.
- Waits for the bus to settle, decodes each stable segment pattern back to a 4-bit digit value, and keeps a per-digit register file.
- Used for display loopback self-test and for scraping values from legacy display-driving logic.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronized cycles {an,seg} must hold unchanged before capture; legal range 1..255.
- NUM_DIGITS, 8, number of anodes monitored; fixed at 8 in this revision.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- an  in  8  anode enables, active-low; bit i selects digit i.
- seg  in  7  segments, active-low; seg[0]=CA(a) … seg[6]=CG(g).
- digits  out  32  digit i value at [4i+3:4i].
- digit_valid  out  8  bit i set once digit i has captured a legal pattern.
- upd  out  1  one-cycle pulse when a digit register is written.
- upd_idx  out  3  index written; meaningful only while upd=1.
- err_pat  out  1  one-cycle pulse: stable, single anode, illegal segment pattern.
- err_an  out  1  one-cycle pulse: stable with more than one anode low.

Behaviour:
- Reset is synchronous (rst sampled at clk edge).
- While rst=1:
  - All outputs are cleared to 0.
  - Synchronizers, previous-value register and counter are cleared; the FSM goes to SETTLE.
  - The capture sequence is aborted with no partial writes.
- Input conditioning: {an,seg} passes through a 2-flop synchronizer (s2); prev holds s2 delayed by one cycle.
- Counter cnt, width $clog2(STABLE_CYCLES+1):
  - Cleared when s2 != prev.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM state SETTLE:
  - When cnt reaches STABLE_CYCLES, the evaluate step runs that cycle and the FSM moves to HOLD.
  - Pin-to-pulse latency is exactly STABLE_CYCLES+2 clocks after a pin change that is then held.
- FSM state HOLD:
  - No further evaluation.
  - Returns to SETTLE on the first cycle s2 != prev, so each stable interval is evaluated exactly once.
- Evaluate step:
  - an == 8'hFF (blanking): no action, no pulses.
  - Exactly one an bit low (index i) and seg is a legal pattern:
    - digits[i] <= value; digit_valid[i] <= 1.
    - upd=1, upd_idx=i.
    - The write occurs even if the value is unchanged.
  - Exactly one an bit low and seg is illegal: err_pat=1; digits[i] and digit_valid[i] are unchanged.
  - Two or more an bits low: err_an=1; nothing is written.
- Legal patterns, seg[6:0] (1 = off), listed as hex→value:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
- Outputs:
  - upd, err_pat and err_an are mutually exclusive and last one cycle.
  - All outputs are registered.
- A change on the bus during SETTLE restarts the count; glitches shorter than STABLE_CYCLES never capture.

Optional Feature:
- Macro SEG7_SCAN_HEX_EN.
- Defined: additionally accepts hex glyphs 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
- Undefined: those six patterns are illegal and raise err_pat.

Decomposition:
- Shared package seg7_pkg holds:
  - typedef seg_t (logic [6:0]).
  - SEG_BLANK = 7'h7F.
  - The ten decimal glyph constants and six hex glyph constants.
  - The function seg_to_val(seg) → {legal, 4-bit value}, also reusable by the existing encoder's testbench.
- One sub-module: seg7_sync_stable, containing the 2-flop synchronizer, prev register, saturating counter and a "stable_now" strobe.
- The top level contains the FSM, the one-hot anode check and the register file.

Test Plan:
- Reset, then hold an=FE, seg=30 → upd pulses 6 clocks after the pin change (STABLE_CYCLES=4); upd_idx=0; digits[3:0]=3; digit_valid=01.
- Scan an=FE/seg=79 then an=7F/seg=10, 20 cycles each → two upd pulses; digits[3:0]=1, digits[31:28]=9, digit_valid=81; no repeat pulse during hold.
- an=FB with seg toggling every 2 cycles for 30 cycles, then held at 12 → exactly one upd after settling, with digits[11:8]=5.
- an=FC, seg=00 held → err_an pulse once, no upd; an=FD, seg=7E → err_pat once, digit 1 unchanged.
- Hex: an=FE, seg=08 → with SEG7_SCAN_HEX_EN, digits[3:0]=A and upd=1; without it, err_pat=1.
- rst asserted during SETTLE with cnt=2 → no upd; all outputs 0 on the next cycle; a fresh capture works after release.
